// File: rtl/dram_dp_be_if.sv
// Port bundle for the dual-port byte-enable RAM. Requests go in, read results come out, and status flags report back.
interface dram_dp_be_if #(
  parameter int WORD_SIZE = 64,
  parameter int ADDR_SIZE = 8
) ();
  localparam int BYTES = WORD_SIZE / 8;

  logic                 read_enable_1;
  logic                 read_enable_2;
  logic                 write_enable_1;
  logic                 write_enable_2;
  logic [BYTES-1:0]     byte_enable_1;
  logic [BYTES-1:0]     byte_enable_2;
  logic [WORD_SIZE-1:0] data_in_1;
  logic [WORD_SIZE-1:0] data_in_2;
  logic [ADDR_SIZE-1:0] address_1;
  logic [ADDR_SIZE-1:0] address_2;
  logic [WORD_SIZE-1:0] output_1;
  logic [WORD_SIZE-1:0] output_2;
  logic                 output_valid_1;
  logic                 output_valid_2;
  logic                 busy;
  logic                 collision;

  modport master (
    output read_enable_1, read_enable_2, write_enable_1, write_enable_2,
    output byte_enable_1, byte_enable_2, data_in_1, data_in_2,
    output address_1, address_2,
    input  output_1, output_2, output_valid_1, output_valid_2, busy, collision
  );

  modport slave (
    input  read_enable_1, read_enable_2, write_enable_1, write_enable_2,
    input  byte_enable_1, byte_enable_2, data_in_1, data_in_2,
    input  address_1, address_2,
    output output_1, output_2, output_valid_1, output_valid_2, busy, collision
  );
endinterface

// File: rtl/dram_dp_be.sv
// True dual-port synchronous RAM with per-byte write enables.
// Port 1 wins the byte lanes that both ports write in the same cycle.
// Read-during-write can be write-first or read-first, and an output register is optional.
// After reset, a sequencer can clear the whole memory one word per cycle.
module dram_dp_be #(
  parameter int WORD_SIZE      = 64,
  parameter int ADDR_SIZE      = 8,
  parameter int WORD_CAPACITY  = 2**ADDR_SIZE,
  parameter int OUTPUT_REG     = 0,
  parameter int READ_FIRST     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  dram_dp_be_if.slave bus
);
  localparam int BYTES = WORD_SIZE / 8;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(WORD_CAPACITY - 1);
  localparam logic [ADDR_SIZE:0]   CAPACITY  = (ADDR_SIZE+1)'(WORD_CAPACITY);

  typedef enum logic {CLEAR, READY} seq_state_t;

  seq_state_t           state_q, state_d;
  logic [ADDR_SIZE-1:0] clear_count;
  logic [WORD_SIZE-1:0] mem [0:WORD_CAPACITY-1];

  logic                 clearing, busy_int;
  logic                 active_1, active_2, in_range_1, in_range_2, write_1, write_2;
  logic [WORD_SIZE-1:0] read_word_1, read_word_2;
  logic                 stage_valid_1, stage_valid_2;
  logic [WORD_SIZE-1:0] stage_data_1, stage_data_2;
  logic                 collision_q;

  assign clearing   = (state_q == CLEAR);
  assign busy_int   = clearing || (rst && (CLEAR_ON_RESET != 0));
  assign bus.busy   = busy_int;
  assign in_range_1 = {1'b0, bus.address_1} < CAPACITY;
  assign in_range_2 = {1'b0, bus.address_2} < CAPACITY;
  assign active_1   = (bus.read_enable_1 || bus.write_enable_1) && !busy_int && !rst;
  assign active_2   = (bus.read_enable_2 || bus.write_enable_2) && !busy_int && !rst;
  assign write_1    = active_1 && bus.write_enable_1 && in_range_1;
  assign write_2    = active_2 && bus.write_enable_2 && in_range_2;

  // Sequencer state register: reset enters CLEAR only when clear-on-reset is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) state_q <= CLEAR;
      else                     state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave CLEAR after the last word is zeroed. CLEAR is only re-entered through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clear_count == LAST_ADDR) state_d = READY;
  end

  // Clear address counter: restarts on every reset and advances once per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (rst)           clear_count <= '0;
    else if (clearing) clear_count <= clear_count + ADDR_SIZE'(1);
  end

  // Per-port read result: the old word, or the merge of old and own data when write-first. Out-of-range reads return zero.
  always_comb begin
    read_word_1 = '0;
    read_word_2 = '0;
    if (in_range_1) read_word_1 = mem[bus.address_1];
    if (in_range_2) read_word_2 = mem[bus.address_2];
    if (READ_FIRST == 0) begin
      for (int i = 0; i < BYTES; i++) begin
        if (in_range_1 && bus.write_enable_1 && bus.byte_enable_1[i])
          read_word_1[8*i +: 8] = bus.data_in_1[8*i +: 8];
        if (in_range_2 && bus.write_enable_2 && bus.byte_enable_2[i])
          read_word_2[8*i +: 8] = bus.data_in_2[8*i +: 8];
      end
    end
  end

  // Memory array update: the clear sequencer, otherwise byte-lane writes. Port 1 is applied last, so it wins shared lanes.
  always_ff @(posedge clk) begin
    if (clearing && !rst) begin
      mem[clear_count] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (write_2 && bus.byte_enable_2[i])
          mem[bus.address_2][8*i +: 8] <= bus.data_in_2[8*i +: 8];
        if (write_1 && bus.byte_enable_1[i])
          mem[bus.address_1][8*i +: 8] <= bus.data_in_1[8*i +: 8];
      end
    end
  end

  // First result stage: capture read data for active ports. Data holds while no port is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_1 <= 1'b0;
      stage_valid_2 <= 1'b0;
      stage_data_1  <= '0;
      stage_data_2  <= '0;
    end else begin
      stage_valid_1 <= active_1;
      stage_valid_2 <= active_2;
      if (active_1) stage_data_1 <= read_word_1;
      if (active_2) stage_data_2 <= read_word_2;
    end
  end

  // Collision flag: pulses one cycle after both ports write overlapping lanes of the same word.
  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= write_1 && write_2 && (bus.address_1 == bus.address_2) &&
                            ((bus.byte_enable_1 & bus.byte_enable_2) != '0);
  end

  assign bus.collision = collision_q;

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic                 out_valid_1, out_valid_2;
      logic [WORD_SIZE-1:0] out_data_1, out_data_2;

      // Optional second stage: adds one cycle of latency and keeps the hold-last-value behaviour.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_1 <= 1'b0;
          out_valid_2 <= 1'b0;
          out_data_1  <= '0;
          out_data_2  <= '0;
        end else begin
          out_valid_1 <= stage_valid_1;
          out_valid_2 <= stage_valid_2;
          if (stage_valid_1) out_data_1 <= stage_data_1;
          if (stage_valid_2) out_data_2 <= stage_data_2;
        end
      end

      assign bus.output_1       = out_data_1;
      assign bus.output_2       = out_data_2;
      assign bus.output_valid_1 = out_valid_1;
      assign bus.output_valid_2 = out_valid_2;
    end else begin : g_no_out_reg
      assign bus.output_1       = stage_data_1;
      assign bus.output_2       = stage_data_2;
      assign bus.output_valid_1 = stage_valid_1;
      assign bus.output_valid_2 = stage_valid_2;
    end
  endgenerate
endmodule

// File: tb/tb_dram_dp_be.sv
// Bench for dram_dp_be. Two instances receive the same stimulus:
// A uses the defaults (write-first, latency 1, 256 words).
// B is read-first with the output register and 200 words.
// A behavioural memory model predicts every output of both instances.
module tb_dram_dp_be;
  localparam int WS    = 64;
  localparam int AS    = 8;
  localparam int CAP_A = 256;
  localparam int CAP_B = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, indexed by port (0 -> port 1, 1 -> port 2).
  logic          pre [2];
  logic          pwe [2];
  logic [7:0]    pbe [2];
  logic [WS-1:0] pd  [2];
  logic [AS-1:0] pa  [2];

  dram_dp_be_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus_a ();
  dram_dp_be_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus_b ();

  dram_dp_be #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .WORD_CAPACITY(CAP_A), .OUTPUT_REG(0),
               .READ_FIRST(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  dram_dp_be #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .WORD_CAPACITY(CAP_B), .OUTPUT_REG(1),
               .READ_FIRST(1), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.read_enable_1  = pre[0];
  assign bus_a.read_enable_2  = pre[1];
  assign bus_a.write_enable_1 = pwe[0];
  assign bus_a.write_enable_2 = pwe[1];
  assign bus_a.byte_enable_1  = pbe[0];
  assign bus_a.byte_enable_2  = pbe[1];
  assign bus_a.data_in_1      = pd[0];
  assign bus_a.data_in_2      = pd[1];
  assign bus_a.address_1      = pa[0];
  assign bus_a.address_2      = pa[1];
  assign bus_b.read_enable_1  = pre[0];
  assign bus_b.read_enable_2  = pre[1];
  assign bus_b.write_enable_1 = pwe[0];
  assign bus_b.write_enable_2 = pwe[1];
  assign bus_b.byte_enable_1  = pbe[0];
  assign bus_b.byte_enable_2  = pbe[1];
  assign bus_b.data_in_1      = pd[0];
  assign bus_b.data_in_2      = pd[1];
  assign bus_b.address_1      = pa[0];
  assign bus_b.address_2      = pa[1];

  // Reference model state, indexed by [instance] or [instance][port].
  int            cap  [2] = '{CAP_A, CAP_B};
  int            rf   [2] = '{0, 1};
  int            oreg [2] = '{0, 1};
  logic [WS-1:0] mmem [2][256];
  int            clr_left [2];
  logic          exp_v    [2][2];
  logic [WS-1:0] exp_o    [2][2];
  logic          s1v      [2][2];
  logic [WS-1:0] s1d      [2][2];
  logic          exp_col  [2];
  logic          exp_busy [2];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [WS-1:0] merge(input logic [WS-1:0] old, input logic [WS-1:0] nw,
                                          input logic [7:0] be);
    logic [WS-1:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one request cycle, using the inputs currently driven.
  task automatic modelStep();
    logic          busy_pre, inr [2], act [2];
    logic [WS-1:0] res [2], old;
    for (int d = 0; d < 2; d++) begin
      busy_pre = (clr_left[d] > 0) || (rst === 1'b1);
      if (rst === 1'b1) begin
        clr_left[d] = cap[d];
        for (int a = 0; a < 256; a++) mmem[d][a] = '0;
        for (int p = 0; p < 2; p++) begin
          exp_v[d][p] = 1'b0; exp_o[d][p] = '0; s1v[d][p] = 1'b0; s1d[d][p] = '0;
        end
        exp_col[d] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          act[p] = (pre[p] || pwe[p]) && !busy_pre;
          inr[p] = int'(pa[p]) < cap[d];
          old    = inr[p] ? mmem[d][pa[p]] : '0;
          if (!inr[p])                  res[p] = '0;
          else if (pwe[p] && rf[d] == 0) res[p] = merge(old, pd[p], pbe[p]);
          else                          res[p] = old;
        end
        for (int p = 1; p >= 0; p--)
          if (act[p] && pwe[p] && inr[p]) mmem[d][pa[p]] = merge(mmem[d][pa[p]], pd[p], pbe[p]);
        exp_col[d] = act[0] && act[1] && pwe[0] && pwe[1] && inr[0] && inr[1] &&
                     (pa[0] == pa[1]) && ((pbe[0] & pbe[1]) != 8'h00);
        if (clr_left[d] > 0) clr_left[d]--;
        for (int p = 0; p < 2; p++) begin
          if (oreg[d] == 0) begin
            exp_v[d][p] = act[p];
            if (act[p]) exp_o[d][p] = res[p];
          end else begin
            exp_v[d][p] = s1v[d][p];
            if (s1v[d][p]) exp_o[d][p] = s1d[d][p];
            s1v[d][p] = act[p];
            if (act[p]) s1d[d][p] = res[p];
          end
        end
      end
      exp_busy[d] = (clr_left[d] > 0) || (rst === 1'b1);
    end
  endtask

  task automatic checkOutput();
    check("A output_1", bus_a.output_1, exp_o[0][0]);
    check("A output_2", bus_a.output_2, exp_o[0][1]);
    check("A valid_1", 64'(bus_a.output_valid_1), 64'(exp_v[0][0]));
    check("A valid_2", 64'(bus_a.output_valid_2), 64'(exp_v[0][1]));
    check("A busy", 64'(bus_a.busy), 64'(exp_busy[0]));
    check("A collision", 64'(bus_a.collision), 64'(exp_col[0]));
    check("B output_1", bus_b.output_1, exp_o[1][0]);
    check("B output_2", bus_b.output_2, exp_o[1][1]);
    check("B valid_1", 64'(bus_b.output_valid_1), 64'(exp_v[1][0]));
    check("B valid_2", 64'(bus_b.output_valid_2), 64'(exp_v[1][1]));
    check("B busy", 64'(bus_b.busy), 64'(exp_busy[1]));
    check("B collision", 64'(bus_b.collision), 64'(exp_col[1]));
  endtask

  // Model the current inputs, clock once, then compare all outputs 1 ns after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      pre[p] = 1'b0; pwe[p] = 1'b0; pbe[p] = 8'h00; pd[p] = '0; pa[p] = '0;
    end
  endtask

  task automatic setPort(input int p, input logic re, input logic we, input logic [7:0] be,
                         input logic [WS-1:0] d, input logic [AS-1:0] a);
    pre[p] = re; pwe[p] = we; pbe[p] = be; pd[p] = d; pa[p] = a;
  endtask

  // Run idle cycles until both instances leave busy, and check how long each took.
  task automatic waitClear();
    int done_a, done_b;
    done_a = 0; done_b = 0;
    idle();
    for (int k = 1; k <= 400 && (done_a == 0 || done_b == 0); k++) begin
      applyStimulus();
      if (done_a == 0 && bus_a.busy === 1'b0) done_a = k;
      if (done_b == 0 && bus_b.busy === 1'b0) done_b = k;
    end
    check("A clear length", 64'(done_a), 64'(CAP_A));
    check("B clear length", 64'(done_b), 64'(CAP_B));
  endtask

  initial begin
    idle();
    for (int d = 0; d < 2; d++) clr_left[d] = 0;
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    waitClear();

    // Preload addr 5, then reset again; the clear sequence must wipe it.
    setPort(0, 1'b0, 1'b1, 8'hFF, 64'hDEAD_BEEF_0000_0001, 8'd5);
    applyStimulus();
    idle(); rst = 1'b1; applyStimulus(); rst = 1'b0;
    waitClear();
    setPort(0, 1'b1, 1'b0, 8'h00, '0, 8'd5);
    applyStimulus();
    check("A clear read valid", 64'(bus_a.output_valid_1), 64'd1);
    check("A clear read data", bus_a.output_1, 64'h0);

    // Byte-enable merge.
    setPort(0, 1'b0, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd3); applyStimulus();
    setPort(0, 1'b0, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 8'd3); applyStimulus();
    setPort(0, 1'b1, 1'b0, 8'h00, '0, 8'd3); applyStimulus();
    check("A byte-enable read", bus_a.output_1, 64'hFFFF_FFFF_5566_7788);
    idle(); applyStimulus();
    check("B byte-enable read", bus_b.output_1, 64'hFFFF_FFFF_5566_7788);

    // Read-during-write, same port and cross port.
    setPort(0, 1'b0, 1'b1, 8'hFF, 64'hA, 8'd7); applyStimulus();
    idle();
    setPort(1, 1'b0, 1'b1, 8'hFF, 64'hB, 8'd7);
    setPort(0, 1'b1, 1'b0, 8'h00, '0, 8'd7);
    applyStimulus();
    check("A rdw port2 write-first", bus_a.output_2, 64'hB);
    check("A rdw port1 cross", bus_a.output_1, 64'hA);
    idle(); applyStimulus();
    check("B rdw port2 read-first", bus_b.output_2, 64'hA);
    check("B rdw port1 cross", bus_b.output_1, 64'hA);

    // Same-address collision with overlapping lanes.
    setPort(0, 1'b0, 1'b1, 8'h03, 64'h1111, 8'd9);
    setPort(1, 1'b0, 1'b1, 8'h06, 64'h2222, 8'd9);
    applyStimulus();
    check("A collision pulse", 64'(bus_a.collision), 64'd1);
    idle(); applyStimulus();
    check("A collision cleared", 64'(bus_a.collision), 64'd0);
    setPort(0, 1'b1, 1'b0, 8'h00, '0, 8'd9); applyStimulus();
    check("A collision word", bus_a.output_1, 64'h1111);
    idle(); applyStimulus();
    check("B collision word", bus_b.output_1, 64'h1111);

    // Back-to-back reads through the two-stage pipeline.
    for (int i = 0; i < 3; i++) begin
      setPort(0, 1'b0, 1'b1, 8'hFF, 64'h100 + 64'(i), 8'(i)); applyStimulus();
    end
    idle(); applyStimulus();
    for (int i = 0; i < 3; i++) begin
      setPort(0, 1'b1, 1'b0, 8'h00, '0, 8'(i)); applyStimulus();
      if (i > 0) check("B pipeline data", bus_b.output_1, 64'h100 + 64'(i - 1));
      check("B pipeline valid", 64'(bus_b.output_valid_1), 64'(i > 0));
    end
    idle(); applyStimulus();
    check("B pipeline last", bus_b.output_1, 64'h102);
    check("B pipeline last valid", 64'(bus_b.output_valid_1), 64'd1);
    applyStimulus();
    check("B pipeline gap valid", 64'(bus_b.output_valid_1), 64'd0);

    // Reset in the middle of clearing restarts the sequence.
    rst = 1'b1; applyStimulus(); rst = 1'b0;
    for (int k = 0; k < 100; k++) applyStimulus();
    rst = 1'b1; applyStimulus(); rst = 1'b0;
    waitClear();

    // Random traffic. Addresses are mostly low so that ports collide; some reach B's out-of-range region.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        pre[p] = 1'($urandom_range(0, 1));
        pwe[p] = 1'($urandom_range(0, 1));
        pbe[p] = 8'($urandom);
        pd[p]  = {32'($urandom), 32'($urandom)};
        pa[p]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      end
      applyStimulus();
    end
    idle(); applyStimulus(); applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_dp_be.md
Name: dram_dp_be

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables and selectable read-during-write mode.
- Adds an optional output pipeline register, port-valid flags, deterministic same-address write arbitration, and a reset-triggered memory-clear sequencer.
- Serves as the general storage primitive for monitoring-trace buffers and per-PC lookup tables. Both ports are fully independent read/write ports.

Parameters:
- WORD_SIZE, 64, data width in bits; must be a multiple of 8.
- ADDR_SIZE, 8, address width.
- WORD_CAPACITY, 2**ADDR_SIZE, number of words; must be <= 2**ADDR_SIZE.
- BYTES, WORD_SIZE/8, byte lanes per word (derived; not overridden).
- OUTPUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2.
- READ_FIRST, 0, 0: write-first (same-port write returns new word); 1: read-first (returns old word).
- CLEAR_ON_RESET, 1, 1: zero all words after reset; 0: memory contents untouched by reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- read_enable_1 / read_enable_2  input  1  read request on port 1 / 2.
- write_enable_1 / write_enable_2  input  1  write request on port 1 / 2.
- byte_enable_1 / byte_enable_2  input  BYTES  per-lane write mask; lane i is bits [8i+7:8i].
- data_in_1 / data_in_2  input  WORD_SIZE  write data.
- address_1 / address_2  input  ADDR_SIZE  word address.
- output_1 / output_2  output  WORD_SIZE  read data.
- output_valid_1 / output_valid_2  output  1  output_x carries the result of an access.
- busy  output  1  clear sequence in progress; port requests are ignored.
- collision  output  1  one-cycle pulse: both ports wrote the same address with overlapping byte enables.

Behaviour:
- Reset is synchronous and active-high: while rst=1, output_1/2=0, output_valid_1/2=0, collision=0, clear counter=0 and pipeline registers=0.
- busy=1 while rst=1 if CLEAR_ON_RESET=1, otherwise busy=0.
- Sequencer states: CLEAR and READY.
  - rst forces CLEAR if CLEAR_ON_RESET=1, else READY.
  - In CLEAR, one word is written to 0 per cycle at address counter 0..WORD_CAPACITY-1.
  - After writing WORD_CAPACITY-1 the state goes to READY. busy deasserts on the first READY cycle, exactly WORD_CAPACITY cycles after rst falls.
  - rst asserted mid-clear restarts the counter at 0.
  - CLEAR is never re-entered without rst.
- While busy=1, all port requests are ignored: no memory write, output_valid=0, outputs hold.
- Access: a port is active when read_enable_x or write_enable_x is 1, with busy=0.
  - An active port produces output_valid_x=1 exactly 1+OUTPUT_REG cycles later. Otherwise valid is 0 in that slot.
  - output_x holds its last value when no result arrives; it is not cleared.
- Writes: only lanes with byte_enable=1 are updated. A write with byte_enable all-zero modifies nothing but still produces a valid read result.
- Same-port read-during-write:
  - READ_FIRST=0 returns the merged word: new bytes in enabled lanes, old bytes elsewhere.
  - READ_FIRST=1 returns the pre-write word.
- Cross-port read of an address written by the other port in the same cycle returns the pre-write word, independent of READ_FIRST.
- Both ports write the same address in one cycle:
  - Per lane, port 1 wins where both byte_enables are set.
  - Lanes enabled by only one port take that port's data.
  - Each port's returned word follows its own READ_FIRST rule using its own data only.
  - collision=1 one cycle later (independent of OUTPUT_REG) iff byte_enable_1 & byte_enable_2 != 0.
- Addresses >= WORD_CAPACITY: writes are dropped and reads return 0. output_valid still asserts.
- No throughput stalls: both ports accept a new request every cycle when busy=0.

Test Plan:
- Clear: preload address 5 with 64'hDEAD_BEEF_0000_0001, pulse rst 1 cycle (defaults) -> busy high for exactly 256 cycles; read address 5 then returns 0 with output_valid_1=1 one cycle after the request.
- Byte enables: write 64'hFFFF_FFFF_FFFF_FFFF to addr 3, then write 64'h1122_3344_5566_7788 with byte_enable_1=8'h0F -> read returns 64'hFFFF_FFFF_5566_7788.
- Read-during-write: addr 7 holds 64'hA, write 64'hB to addr 7 on port 2 while port 1 reads addr 7.
  - Port 2 returns 64'hB when READ_FIRST=0 and 64'hA when READ_FIRST=1.
  - Port 1 returns 64'hA in both modes.
- Collision: both ports write addr 9, byte_enable_1=8'h03 data 64'h1111, byte_enable_2=8'h06 data 64'h2222 -> memory byte0=11, byte1=11, byte2=00 (from 64'h2222); collision=1 for exactly one cycle.
- Latency: OUTPUT_REG=1, back-to-back reads of addrs 0,1,2 on port 1 -> output_valid_1 high on cycles 2,3,4 with the matching data; no gaps.
- Reset mid-clear: assert rst at clear count 100 -> busy stays high; counter restarts at 0; total busy = 256 cycles after the second rst falls.
